// File: rtl/counter_pkg.sv
// Shared constants and helpers for the prescaled counter family.
// Mode and direction encodings match the SATURATE parameter and the dir input.
package counter_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // The prescaler register is max(1, clog2(prescale)) bits wide.
    function automatic int prescale_width(input int prescale);
        return (prescale > 2) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle tick on the last one.
// clr restarts the phase so a load begins a fresh prescale period.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = prescale_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] pcount;

    generate
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("tick_prescaler: PRESCALE must be >= 1");
        end
    endgenerate

    assign tick = en && (pcount == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcount <= '0;
        end else if (clr) begin
            pcount <= '0;
        end else if (en) begin
            if (pcount == LAST) begin
                pcount <= '0;
            end else begin
                pcount <= pcount + ONE;
            end
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// Parametrised up/down counter with prescaler, parallel load and wrap/saturate mode.
// outCounter and tc are registered; at_limit follows the count and dir directly.
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MAX_VALUE   = 2**WIDTH - 1,
    parameter int PRESCALE    = 1,
    parameter int SATURATE    = 0,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] outCounter,
    output logic             tc,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("prescaled_counter: WIDTH must be >= 2");
        end
        if (MAX_VALUE < 1 || longint'(MAX_VALUE) >= (longint'(1) << WIDTH)) begin : g_bad_max
            $error("prescaled_counter: MAX_VALUE must be in 1 .. 2**WIDTH-1");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("prescaled_counter: PRESCALE must be >= 1");
        end
        if (SATURATE != MODE_WRAP && SATURATE != MODE_SATURATE) begin : g_bad_mode
            $error("prescaled_counter: SATURATE must be 0 or 1");
        end
        if (RESET_VALUE < 0 || RESET_VALUE > MAX_VALUE) begin : g_bad_reset
            $error("prescaled_counter: RESET_VALUE must be in 0 .. MAX_VALUE");
        end
    endgenerate

    logic             tick;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_count;
    logic             step_tc;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .tick(tick)
    );

    assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;

    // Wrap is explicit against MAX_V so non-power-of-two moduli work.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        step_count = outCounter;
        step_tc    = 1'b0;
        if (dir == DIR_UP) begin
            if (outCounter == MAX_V) begin
                if (SATURATE == MODE_WRAP) begin
                    step_count = '0;
                    step_tc    = 1'b1;
                end
            end else begin
                step_count = outCounter + ONE;
                step_tc    = (SATURATE == MODE_SATURATE) && (outCounter == MAX_V - ONE);
            end
        end else begin
            if (outCounter == '0) begin
                if (SATURATE == MODE_WRAP) begin
                    step_count = MAX_V;
                    step_tc    = 1'b1;
                end
            end else begin
                step_count = outCounter - ONE;
                step_tc    = (SATURATE == MODE_SATURATE) && (outCounter == ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outCounter <= RESET_V;
            tc         <= 1'b0;
        end else if (load) begin
            outCounter <= load_clamped;
            tc         <= 1'b0;
        end else if (tick) begin
            outCounter <= step_count;
            tc         <= step_tc;
        end else begin
            tc         <= 1'b0;
        end
    end

    assign at_limit = (dir == DIR_DOWN) ? (outCounter == '0) : (outCounter == MAX_V);

endmodule

// File: tb/tb_prescaled_counter.sv
// Five differently-parametrised counters, each compared every cycle against an
// arithmetic reference model, plus directed sequences and a load/reset vector table.
module tb_prescaled_counter;

    localparam int N = 5;

    // Instance configurations: 0 defaults, 1 mod-10 /3, 2 saturating mod-6,
    // 3 mod-100 /3 with reset value 7, 4 mod-16 for down counting.
    int c_w   [N] = '{8, 4, 3, 8, 4};
    int c_max [N] = '{255, 9, 5, 99, 15};
    int c_pre [N] = '{1, 3, 1, 3, 1};
    int c_sat [N] = '{0, 0, 1, 0, 0};
    int c_rst [N] = '{0, 0, 0, 7, 0};

    logic           clk;
    logic [N-1:0]   rst_v, en_v, dir_v, ld_v;
    logic [7:0]     lv_a [N];
    logic [N-1:0]   tc_o, lim_o;
    logic [7:0]     cnt0, cnt3;
    logic [3:0]     cnt1, cnt4;
    logic [2:0]     cnt2;
    logic [31:0]    cnt_o [N];

    int m_cnt [N];
    int m_ph  [N];
    bit m_tc  [N];

    int checks = 0;
    int errors = 0;

    prescaled_counter u0 (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .dir(dir_v[0]), .load(ld_v[0]),
        .load_value(lv_a[0]), .outCounter(cnt0), .tc(tc_o[0]), .at_limit(lim_o[0]));

    prescaled_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(3)) u1 (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .dir(dir_v[1]), .load(ld_v[1]),
        .load_value(lv_a[1][3:0]), .outCounter(cnt1), .tc(tc_o[1]), .at_limit(lim_o[1]));

    prescaled_counter #(.WIDTH(3), .MAX_VALUE(5), .PRESCALE(1), .SATURATE(1)) u2 (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .dir(dir_v[2]), .load(ld_v[2]),
        .load_value(lv_a[2][2:0]), .outCounter(cnt2), .tc(tc_o[2]), .at_limit(lim_o[2]));

    prescaled_counter #(.WIDTH(8), .MAX_VALUE(99), .PRESCALE(3), .RESET_VALUE(7)) u3 (
        .clk(clk), .rst(rst_v[3]), .en(en_v[3]), .dir(dir_v[3]), .load(ld_v[3]),
        .load_value(lv_a[3]), .outCounter(cnt3), .tc(tc_o[3]), .at_limit(lim_o[3]));

    prescaled_counter #(.WIDTH(4), .MAX_VALUE(15), .PRESCALE(1)) u4 (
        .clk(clk), .rst(rst_v[4]), .en(en_v[4]), .dir(dir_v[4]), .load(ld_v[4]),
        .load_value(lv_a[4][3:0]), .outCounter(cnt4), .tc(tc_o[4]), .at_limit(lim_o[4]));

    assign cnt_o[0] = {24'd0, cnt0};
    assign cnt_o[1] = {28'd0, cnt1};
    assign cnt_o[2] = {29'd0, cnt2};
    assign cnt_o[3] = {24'd0, cnt3};
    assign cnt_o[4] = {28'd0, cnt4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: counts enabled cycles, steps by +/-1, and folds out-of-range
    // results back with modular arithmetic (wrap) or discards them (saturate).
    task automatic model_update(input int i);
        int nxt;
        int v;
        if (rst_v[i]) begin
            m_cnt[i] = c_rst[i];
            m_ph[i]  = 0;
            m_tc[i]  = 0;
        end else if (ld_v[i]) begin
            v        = int'(lv_a[i]) % (1 << c_w[i]);
            m_cnt[i] = (v > c_max[i]) ? c_max[i] : v;
            m_ph[i]  = 0;
            m_tc[i]  = 0;
        end else if (!en_v[i]) begin
            m_tc[i] = 0;
        end else begin
            m_ph[i]++;
            m_tc[i] = 0;
            if (m_ph[i] == c_pre[i]) begin
                m_ph[i] = 0;
                nxt = m_cnt[i] + (dir_v[i] ? 1 : -1);
                if (nxt < 0 || nxt > c_max[i]) begin
                    if (c_sat[i] == 0) begin
                        m_cnt[i] = (nxt + c_max[i] + 1) % (c_max[i] + 1);
                        m_tc[i]  = 1;
                    end
                end else begin
                    m_cnt[i] = nxt;
                    m_tc[i]  = (c_sat[i] != 0) && (nxt == (dir_v[i] ? c_max[i] : 0));
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < N; i++) model_update(i);
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d count", i), cnt_o[i], m_cnt[i]);
            check($sformatf("u%0d tc", i), 32'(tc_o[i]), 32'(m_tc[i]));
            check($sformatf("u%0d at_limit", i), 32'(lim_o[i]),
                  32'(dir_v[i] ? (m_cnt[i] == c_max[i]) : (m_cnt[i] == 0)));
        end
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic       dir;
        logic       load;
        logic [7:0] lv;
        int         cnt;
        logic       tc;
        logic       lim;
    } vec_t;

    vec_t vt [20];

    initial begin
        // Load, clamp, prescaler restart and reset priority on u3 (mod 100, /3, reset 7).
        vt[0]  = '{0, 1, 1, 0, 8'd0,   7,  0, 0};
        vt[1]  = '{0, 1, 1, 0, 8'd0,   7,  0, 0};
        vt[2]  = '{0, 1, 1, 0, 8'd0,   8,  0, 0};
        vt[3]  = '{0, 1, 1, 0, 8'd0,   8,  0, 0};
        vt[4]  = '{0, 1, 1, 1, 8'd200, 99, 0, 1};
        vt[5]  = '{0, 1, 1, 0, 8'd0,   99, 0, 1};
        vt[6]  = '{0, 1, 1, 0, 8'd0,   99, 0, 1};
        vt[7]  = '{0, 1, 1, 0, 8'd0,   0,  1, 0};
        vt[8]  = '{0, 1, 0, 0, 8'd0,   0,  0, 1};
        vt[9]  = '{0, 1, 0, 0, 8'd0,   0,  0, 1};
        vt[10] = '{0, 1, 0, 0, 8'd0,   99, 1, 0};
        vt[11] = '{0, 1, 1, 0, 8'd0,   99, 0, 1};
        vt[12] = '{0, 1, 1, 0, 8'd0,   99, 0, 1};
        vt[13] = '{1, 1, 1, 1, 8'd3,   7,  0, 0};
        vt[14] = '{0, 1, 1, 0, 8'd0,   7,  0, 0};
        vt[15] = '{0, 1, 1, 0, 8'd0,   7,  0, 0};
        vt[16] = '{0, 1, 1, 0, 8'd0,   8,  0, 0};
        vt[17] = '{0, 0, 1, 1, 8'd99,  99, 0, 1};
        vt[18] = '{0, 0, 0, 0, 8'd0,   99, 0, 0};
        vt[19] = '{0, 0, 1, 1, 8'd255, 99, 0, 1};

        rst_v = '1; en_v = '0; dir_v = '1; ld_v = '0;
        for (int i = 0; i < N; i++) begin
            lv_a[i]  = 8'd0;
            m_cnt[i] = c_rst[i];
            m_ph[i]  = 0;
            m_tc[i]  = 0;
        end
        cycle();
        cycle();
        check("reset u3 value", cnt_o[3], 7);
        check("reset u0 value", cnt_o[0], 0);
        rst_v = '0;

        // Default counter: 0..255 then wrap with a single tc.
        en_v[0] = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            cycle();
            check("t1 count", cnt_o[0], k % 256);
            check("t1 tc", 32'(tc_o[0]), 32'(k == 256));
            check("t1 at_limit", 32'(lim_o[0]), 32'(k % 256 == 255));
        end
        en_v[0] = 1'b0;

        // Mod-10 with /3: a step every 3 cycles, one tc per 30 cycles.
        en_v[1] = 1'b1;
        begin
            int tcs = 0;
            for (int k = 1; k <= 30; k++) begin
                cycle();
                check("t2 count", cnt_o[1], (k / 3) % 10);
                tcs += int'(tc_o[1]);
            end
            check("t2 tc per 30 cycles", tcs, 1);
        end
        cycle();
        en_v[1] = 1'b0;
        cycle();
        cycle();
        check("t2 stalled", cnt_o[1], 0);
        en_v[1] = 1'b1;
        cycle();
        check("t2 one before delayed step", cnt_o[1], 0);
        cycle();
        check("t2 delayed step", cnt_o[1], 1);
        en_v[1] = 1'b0;

        // Saturating mod-6: stick at 5 going up, at 0 going down.
        en_v[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("t3 up count", cnt_o[2], (k < 5) ? k : 5);
            check("t3 up tc", 32'(tc_o[2]), 32'(k == 5));
        end
        check("t3 at_limit up", 32'(lim_o[2]), 1);
        dir_v[2] = 1'b0;
        #1;
        check("t3 at_limit after dir change", 32'(lim_o[2]), 0);
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("t3 down count", cnt_o[2], (k < 5) ? 5 - k : 0);
            check("t3 down tc", 32'(tc_o[2]), 32'(k == 5));
        end
        en_v[2] = 1'b0;

        for (int r = 0; r < 20; r++) begin
            rst_v[3] = vt[r].rst;
            en_v[3]  = vt[r].en;
            dir_v[3] = vt[r].dir;
            ld_v[3]  = vt[r].load;
            lv_a[3]  = vt[r].lv;
            cycle();
            check($sformatf("vec %0d count", r), cnt_o[3], vt[r].cnt);
            check($sformatf("vec %0d tc", r), 32'(tc_o[3]), 32'(vt[r].tc));
            check($sformatf("vec %0d at_limit", r), 32'(lim_o[3]), 32'(vt[r].lim));
        end
        rst_v[3] = 1'b0; ld_v[3] = 1'b0; en_v[3] = 1'b0;

        // Wrap-mode down count from reset: 15 with tc, then 14, 13, ...
        dir_v[4] = 1'b0;
        en_v[4]  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            check("t5 count", cnt_o[4], (16 - (k % 16)) % 16);
            check("t5 tc", 32'(tc_o[4]), 32'(k % 16 == 1));
        end

        // Randomised traffic on every instance against the model.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                rst_v[i] = ($urandom_range(63) == 0);
                ld_v[i]  = ($urandom_range(15) == 0);
                en_v[i]  = ($urandom_range(3) != 0);
                if ($urandom_range(7) == 0) dir_v[i] = ~dir_v[i];
                lv_a[i]  = 8'($urandom_range(255));
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
